// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel-rate divider, horizontal/vertical position
// counters and a registered output stage for sync, blanking, coordinates and frame count.
module vga_timing #(
    parameter int clk_mhz       = 50,
    parameter int pixel_mhz     = 25,
    parameter int screen_width  = 640,
    parameter int h_front       = 16,
    parameter int h_sync        = 96,
    parameter int h_back        = 48,
    parameter int screen_height = 480,
    parameter int v_front       = 10,
    parameter int v_sync        = 2,
    parameter int v_back        = 33,
    parameter bit sync_active   = 1'b0,
    parameter int w_x           = $clog2(screen_width),
    parameter int w_y           = $clog2(screen_height)
) (
    input  logic           clk,
    input  logic           rst,
    output logic           pixel_enable,
    output logic           hsync,
    output logic           vsync,
    output logic           display_on,
    output logic [w_x-1:0] x,
    output logic [w_y-1:0] y,
    output logic           frame_start,
    output logic [7:0]     frame_cnt
);

    localparam int div_n   = (pixel_mhz > 0) ? clk_mhz / pixel_mhz : 1;
    localparam int h_total = screen_width + h_front + h_sync + h_back;
    localparam int v_total = screen_height + v_front + v_sync + v_back;
    localparam int w_div   = (div_n > 1) ? $clog2(div_n) : 1;
    localparam int w_h     = $clog2(h_total);
    localparam int w_v     = $clog2(v_total);

    localparam logic [w_div-1:0] div_last     = w_div'(div_n - 1);
    localparam logic [w_h-1:0]   h_last       = w_h'(h_total - 1);
    localparam logic [w_h-1:0]   h_visible    = w_h'(screen_width);
    localparam logic [w_h-1:0]   h_sync_start = w_h'(screen_width + h_front);
    localparam logic [w_h-1:0]   h_sync_end   = w_h'(screen_width + h_front + h_sync);
    localparam logic [w_v-1:0]   v_last       = w_v'(v_total - 1);
    localparam logic [w_v-1:0]   v_visible    = w_v'(screen_height);
    localparam logic [w_v-1:0]   v_sync_start = w_v'(screen_height + v_front);
    localparam logic [w_v-1:0]   v_sync_end   = w_v'(screen_height + v_front + v_sync);

    if (pixel_mhz < 1 || clk_mhz < pixel_mhz || (clk_mhz % pixel_mhz) != 0) begin : g_ratio_check
        $error("vga_timing: clk_mhz must be an integer multiple of pixel_mhz");
    end

    // Maps a logical "sync asserted" flag onto the configured pin polarity.
    function automatic logic sync_level(input logic active);
        return active ? sync_active : !sync_active;
    endfunction

    logic [w_div-1:0] div_p0;
    logic [w_h-1:0]   hpos_p0;
    logic [w_v-1:0]   vpos_p0;
    logic [7:0]       frames_p0;
    logic             h_wrap_p0;
    logic             v_wrap_p0;
    logic             visible_p0;
    logic             hsync_act_p0;
    logic             vsync_act_p0;
    logic             origin_p0;
    logic             origin_p1;

    // Stage p0: pixel-rate divider and raster position counters.
    assign pixel_enable = !rst && (div_p0 == div_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_p0 <= '0;
        end else if (pixel_enable) begin
            div_p0 <= '0;
        end else begin
            div_p0 <= div_p0 + 1'b1;
        end
    end

    assign h_wrap_p0 = (hpos_p0 == h_last);
    assign v_wrap_p0 = (vpos_p0 == v_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            hpos_p0   <= '0;
            vpos_p0   <= '0;
            frames_p0 <= '0;
        end else if (pixel_enable) begin
            hpos_p0 <= h_wrap_p0 ? '0 : hpos_p0 + 1'b1;
            if (h_wrap_p0) begin
                vpos_p0 <= v_wrap_p0 ? '0 : vpos_p0 + 1'b1;
            end
            if (h_wrap_p0 && v_wrap_p0) begin
                frames_p0 <= frames_p0 + 1'b1;
            end
        end
    end

    assign visible_p0   = (hpos_p0 < h_visible) && (vpos_p0 < v_visible);
    assign hsync_act_p0 = (hpos_p0 >= h_sync_start) && (hpos_p0 < h_sync_end);
    assign vsync_act_p0 = (vpos_p0 >= v_sync_start) && (vpos_p0 < v_sync_end);
    assign origin_p0    = (hpos_p0 == '0) && (vpos_p0 == '0);

    // Stage p1: registered outputs; the origin flag turns the multi-clk
    // display of pixel (0,0) into a single-clk frame_start.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync       <= !sync_active;
            vsync       <= !sync_active;
            display_on  <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
            origin_p1   <= 1'b0;
        end else begin
            hsync       <= sync_level(hsync_act_p0);
            vsync       <= sync_level(vsync_act_p0);
            display_on  <= visible_p0;
            x           <= visible_p0 ? w_x'(hpos_p0) : '0;
            y           <= visible_p0 ? w_y'(vpos_p0) : '0;
            frame_start <= origin_p0 && !origin_p1;
            frame_cnt   <= frames_p0;
            origin_p1   <= origin_p0;
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: three instances (small raster at /2, small raster at /1 with
// inverted sync polarity, default 640x480 raster) checked every clock against a closed-form model.
module tb_vga_timing;

    typedef struct {
        int pe;
        int hs;
        int vs;
        int de;
        int fs;
        int x;
        int y;
        int fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       pe_a, hs_a, vs_a, de_a, fs_a;
    logic [1:0] x_a;
    logic [0:0] y_a;
    logic [7:0] fc_a;

    logic       pe_b, hs_b, vs_b, de_b, fs_b;
    logic [1:0] x_b;
    logic [0:0] y_b;
    logic [7:0] fc_b;

    logic       pe_c, hs_c, vs_c, de_c, fs_c;
    logic [9:0] x_c;
    logic [8:0] y_c;
    logic [7:0] fc_c;

    int   total = 0;
    int   bad   = 0;
    int   k     = -1;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    always #5 clk = ~clk;

    vga_timing #(
        .clk_mhz(50), .pixel_mhz(25),
        .screen_width(4), .h_front(1), .h_sync(2), .h_back(1),
        .screen_height(2), .v_front(1), .v_sync(2), .v_back(1),
        .sync_active(1'b0)
    ) dut_a (
        .clk(clk), .rst(rst), .pixel_enable(pe_a), .hsync(hs_a), .vsync(vs_a),
        .display_on(de_a), .x(x_a), .y(y_a), .frame_start(fs_a), .frame_cnt(fc_a)
    );

    vga_timing #(
        .clk_mhz(25), .pixel_mhz(25),
        .screen_width(4), .h_front(1), .h_sync(2), .h_back(1),
        .screen_height(2), .v_front(1), .v_sync(2), .v_back(1),
        .sync_active(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .pixel_enable(pe_b), .hsync(hs_b), .vsync(vs_b),
        .display_on(de_b), .x(x_b), .y(y_b), .frame_start(fs_b), .frame_cnt(fc_b)
    );

    vga_timing dut_c (
        .clk(clk), .rst(rst), .pixel_enable(pe_c), .hsync(hs_c), .vsync(vs_c),
        .display_on(de_c), .x(x_c), .y(y_c), .frame_start(fs_c), .frame_cnt(fc_c)
    );

    // kk = clocks since the first edge that sampled rst low; -1 while in reset.
    function automatic exp_t model(input int kk, input int n, input int sa,
                                   input int sw, input int hf, input int hsw, input int hb,
                                   input int sh, input int vf, input int vsw, input int vb);
        exp_t e;
        int ht, vt, p, pix, h, v;
        if (kk < 0) begin
            e.pe = 0; e.hs = 1 - sa; e.vs = 1 - sa; e.de = 0;
            e.fs = 0; e.x = 0; e.y = 0; e.fc = 0;
            return e;
        end
        ht   = sw + hf + hsw + hb;
        vt   = sh + vf + vsw + vb;
        p    = kk / n;
        pix  = p % (ht * vt);
        h    = pix % ht;
        v    = pix / ht;
        e.pe = (((kk + 1) % n) == (n - 1)) ? 1 : 0;
        e.de = (h < sw && v < sh) ? 1 : 0;
        e.x  = e.de ? h : 0;
        e.y  = e.de ? v : 0;
        e.hs = (h >= sw + hf && h < sw + hf + hsw) ? sa : 1 - sa;
        e.vs = (v >= sh + vf && v < sh + vf + vsw) ? sa : 1 - sa;
        e.fs = ((kk % (n * ht * vt)) == 0) ? 1 : 0;
        e.fc = (p / (ht * vt)) % 256;
        return e;
    endfunction

    task automatic check(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d (k=%0d)", tag, obs, expv, k);
        end
    endtask

    task automatic cmp(input string d, input exp_t o, input exp_t e);
        check({d, ".pixel_enable"}, o.pe, e.pe);
        check({d, ".hsync"},        o.hs, e.hs);
        check({d, ".vsync"},        o.vs, e.vs);
        check({d, ".display_on"},   o.de, e.de);
        check({d, ".frame_start"},  o.fs, e.fs);
        check({d, ".x"},            o.x,  e.x);
        check({d, ".y"},            o.y,  e.y);
        check({d, ".frame_cnt"},    o.fc, e.fc);
    endtask

    // Drive rst for the next edge, queue what each DUT must show after it, then compare.
    task automatic step(input bit r);
        exp_t e;
        exp_t o;
        rst = r;
        k   = r ? -1 : k + 1;
        q_a.push_back(model(k, 2, 0, 4, 1, 2, 1, 2, 1, 2, 1));
        q_b.push_back(model(k, 1, 1, 4, 1, 2, 1, 2, 1, 2, 1));
        q_c.push_back(model(k, 2, 0, 640, 16, 96, 48, 480, 10, 2, 33));
        @(posedge clk);
        #1;
        e = q_a.pop_front();
        o = '{int'(pe_a), int'(hs_a), int'(vs_a), int'(de_a), int'(fs_a), int'(x_a), int'(y_a), int'(fc_a)};
        cmp("a", o, e);
        e = q_b.pop_front();
        o = '{int'(pe_b), int'(hs_b), int'(vs_b), int'(de_b), int'(fs_b), int'(x_b), int'(y_b), int'(fc_b)};
        cmp("b", o, e);
        e = q_c.pop_front();
        o = '{int'(pe_c), int'(hs_c), int'(vs_c), int'(de_c), int'(fs_c), int'(x_c), int'(y_c), int'(fc_c)};
        cmp("c", o, e);
    endtask

    initial begin
        repeat (3) step(1'b1);
        check("reset.hsync_a", int'(hs_a), 1);
        check("reset.hsync_b", int'(hs_b), 0);

        step(1'b0);
        check("release.frame_start_a", int'(fs_a), 1);
        check("release.display_on_c", int'(de_c), 1);

        // 256 frames of the small raster at /2 (48 pixels, 96 clks per frame).
        repeat (256 * 96 - 1) step(1'b0);
        step(1'b0);
        check("wrap256.frame_cnt_a", int'(fc_a), 0);
        check("wrap256.frame_start_a", int'(fs_a), 1);

        // Abort mid-frame and mid-line with a single-clk reset pulse.
        repeat (137) step(1'b0);
        step(1'b1);
        step(1'b0);
        check("midrst.x_a", int'(x_a), 0);
        check("midrst.frame_start_a", int'(fs_a), 1);
        check("midrst.frame_cnt_a", int'(fc_a), 0);
        check("midrst.hsync_c", int'(hs_c), 1);
        check("midrst.vsync_b", int'(vs_b), 0);

        repeat (300) step(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter clk_mhz, default 50: system clock frequency in MHz.
REQ-002 Parameter pixel_mhz, default 25: pixel rate in MHz; clk_mhz / pixel_mhz SHALL be an integer >= 1, otherwise elaboration error.
REQ-003 Parameters screen_width 640, h_front 16, h_sync 96, h_back 48: horizontal timing in pixels.
REQ-004 Parameters screen_height 480, v_front 10, v_sync 2, v_back 33: vertical timing in lines.
REQ-005 Parameter sync_active, default 0: active level of hsync/vsync.
REQ-006 Parameters w_x = $clog2(screen_width), w_y = $clog2(screen_height): coordinate widths.
REQ-007 clk  input  1  system clock, all logic on rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 pixel_enable  output  1  one-clk strobe per pixel period.
REQ-010 hsync  output  1  horizontal sync.
REQ-011 vsync  output  1  vertical sync.
REQ-012 display_on  output  1  high inside the visible area.
REQ-013 x  output  w_x  visible column; 0 when display_on low.
REQ-014 y  output  w_y  visible row; 0 when display_on low.
REQ-015 frame_start  output  1  one-clk pulse at first visible pixel of a frame.
REQ-016 frame_cnt  output  8  frames completed, mod 256.

Function
REQ-017 Divider: N = clk_mhz / pixel_mhz; counter 0..N-1, wraps; pixel_enable high in the cycle the counter equals N-1; N = 1 -> pixel_enable constantly high.
REQ-018 H_TOTAL = screen_width + h_front + h_sync + h_back (800); V_TOTAL = screen_height + v_front + v_sync + v_back (525).
REQ-019 hpos 0..H_TOTAL-1 increments on pixel_enable; at H_TOTAL-1 wraps to 0.
REQ-020 vpos changes only when hpos wraps: increments, V_TOTAL-1 wraps to 0.
REQ-021 Visible: hpos < screen_width and vpos < screen_height.
REQ-022 hsync active for screen_width+h_front <= hpos < screen_width+h_front+h_sync (656..751); else inactive.
REQ-023 vsync active for screen_height+v_front <= vpos < screen_height+v_front+v_sync (490..491); else inactive.
REQ-024 All outputs except pixel_enable registered every clk from current hpos/vpos: one clk latency from counter to output.
REQ-025 frame_start high for exactly one clk: the first clk in which the output stage shows hpos=0, vpos=0.
REQ-026 frame_cnt increments by 1 when hpos and vpos both wrap on the same pixel_enable; 255 wraps to 0.
REQ-027 Outputs hold between pixel_enable strobes; x/y never exceed screen_width-1 / screen_height-1.

Reset
REQ-028 While rst high: divider, hpos, vpos, frame_cnt = 0; pixel_enable = 0; hsync = vsync = !sync_active; display_on = 0; x = y = 0; frame_start = 0.
REQ-029 rst asserted mid-line or mid-frame SHALL abort immediately; first clk after rst deasserts, outputs show hpos=0, vpos=0 (display_on=1, frame_start=1); frame_cnt stays 0.

Verification
REQ-030 Default params, rst 3 clks then release -> pixel_enable every 2nd clk; frame_start pulses 1 clk after release, then every 2*800*525 = 840000 clks.
REQ-031 Per line with defaults -> display_on high for 640 pixels, hsync low for exactly 96 pixels starting at hpos 656, x counts 0..639 then 0.
REQ-032 Per frame with defaults -> vsync low for 2 lines (1600 pixels) starting at vpos 490; y counts 0..479; frame_cnt +1 per frame.
REQ-033 clk_mhz=25, pixel_mhz=25 -> pixel_enable constant 1; frame period 420000 clks.
REQ-034 rst pulsed 1 clk at hpos 700, vpos 300 -> next clk x=0, y=0, display_on=1, frame_start=1, frame_cnt=0, hsync=vsync=1.
REQ-035 Run 256 frames -> frame_cnt returns to 0; sync_active=1 build -> hsync/vsync polarity inverted, timing identical.
